// File: rtl/pmod_intr_pkg.sv
// Shared definitions for the Pmod interrupt register bank: register offsets,
// response codes, channel FSM states and a byte-strobe helper.
package pmod_intr_pkg;

    localparam logic [4:0] ADDR_GIE = 5'h00;
    localparam logic [4:0] ADDR_IER = 5'h04;
    localparam logic [4:0] ADDR_ISR = 5'h08;
    localparam logic [4:0] ADDR_IAR = 5'h0C;
    localparam logic [4:0] ADDR_IPR = 5'h10;
    localparam logic [4:0] ADDR_ITR = 5'h14;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Expands a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/pmod_intr_axil_slave_if.sv
// AXI4-Lite bus bundle for the interrupt register bank; master side is the
// interconnect, slave side is pmod_intr_axil_slave.
interface pmod_intr_axil_slave_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/pmod_intr_detect.sv
// Per-source interrupt capture (edge or level per sensitivity bit) and ISR
// set/clear arbitration; a set in the same cycle as a clear wins.
module pmod_intr_detect #(
    parameter int          N    = 1,
    parameter logic [31:0] SENS = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] src,
    input  logic [N-1:0] sw_set,
    input  logic [N-1:0] clr,
    output logic [N-1:0] isr
);

    logic [N-1:0] hw_set;
    logic [N-1:0] isr_reg;
    logic [N-1:0] isr_next;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_src
            if (SENS[gi]) begin : g_edge
                logic prev_reg;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        prev_reg <= 1'b0;
                    end else begin
                        prev_reg <= src[gi];
                    end
                end
                assign hw_set[gi] = src[gi] & ~prev_reg;
            end else begin : g_level
                assign hw_set[gi] = src[gi];
            end
        end
    endgenerate

    always_comb begin
        isr_next = (isr_reg & ~clr) | hw_set | sw_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isr_reg <= '0;
        end else begin
            isr_reg <= isr_next;
        end
    end

    assign isr = isr_reg;

endmodule

// File: rtl/pmod_intr_axil_slave.sv
// AXI4-Lite interrupt register bank (GIE/IER/ISR/IAR/IPR/ITR) driving one irq.
// Define PMOD_INTR_SW_TRIGGER_EN to make ITR (0x14) set ISR bits from software.
module pmod_intr_axil_slave
    import pmod_intr_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter int          C_NUM_OF_INTR      = 1,
    parameter logic [31:0] C_INTR_SENSITIVITY = 32'hFFFF_FFFF,
    parameter int          C_IRQ_ACTIVE_STATE = 1
) (
    input  logic                     s_axi_intr_aclk,
    input  logic                     s_axi_intr_aresetn,
    pmod_intr_axil_slave_if.slave    s_axi_intr,
    input  logic [C_NUM_OF_INTR-1:0] intr_src,
    output logic                     irq
);

    localparam int          N        = C_NUM_OF_INTR;
    localparam logic [31:0] SRC_MASK = (N >= 32) ? 32'hFFFF_FFFF : ((32'h1 << N) - 32'h1);
    localparam logic        IRQ_ON   = (C_IRQ_ACTIVE_STATE != 0);

    wr_state_t   wr_state_reg, wr_state_next;
    rd_state_t   rd_state_reg, rd_state_next;
    logic        wr_fire;
    logic        rd_fire;
    logic [2:0]  wr_idx;
    logic [2:0]  rd_idx;
    logic [31:0] wr_mask;
    logic [31:0] wr_bits;

    logic        gie_reg;
    logic [31:0] ier_reg;
    logic [31:0] rdata_reg, rdata_next;
    logic        irq_reg, irq_next;

    logic [N-1:0] isr;
    logic [N-1:0] ack_clr;
    logic [N-1:0] sw_set;
    logic [31:0]  isr_full;
    logic [31:0]  ipr_full;

    logic unused_ok;
    assign unused_ok = ^{s_axi_intr.awprot, s_axi_intr.arprot,
                         s_axi_intr.awaddr[1:0], s_axi_intr.araddr[1:0]};

    assign wr_idx  = s_axi_intr.awaddr[4:2];
    assign rd_idx  = s_axi_intr.araddr[4:2];
    assign wr_mask = strb_mask(s_axi_intr.wstrb);
    assign wr_bits = s_axi_intr.wdata & wr_mask;

    // Write channel: accept only when both AW and W are present and no B is pending.
    always_comb begin
        wr_state_next        = wr_state_reg;
        wr_fire              = 1'b0;
        s_axi_intr.awready   = 1'b0;
        s_axi_intr.wready    = 1'b0;
        s_axi_intr.bvalid    = 1'b0;
        s_axi_intr.bresp     = OKAY;
        case (wr_state_reg)
            W_IDLE: begin
                if (s_axi_intr.awvalid && s_axi_intr.wvalid) begin
                    wr_fire            = 1'b1;
                    s_axi_intr.awready = 1'b1;
                    s_axi_intr.wready  = 1'b1;
                    wr_state_next      = W_RESP;
                end
            end
            W_RESP: begin
                s_axi_intr.bvalid = 1'b1;
                if (s_axi_intr.bready) begin
                    wr_state_next = W_IDLE;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_next      = rd_state_reg;
        rd_fire            = 1'b0;
        s_axi_intr.arready = 1'b0;
        s_axi_intr.rvalid  = 1'b0;
        s_axi_intr.rresp   = OKAY;
        case (rd_state_reg)
            R_IDLE: begin
                if (s_axi_intr.arvalid) begin
                    rd_fire            = 1'b1;
                    s_axi_intr.arready = 1'b1;
                    rd_state_next      = R_DATA;
                end
            end
            R_DATA: begin
                s_axi_intr.rvalid = 1'b1;
                if (s_axi_intr.rready) begin
                    rd_state_next = R_IDLE;
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
        if (!s_axi_intr_aresetn) begin
            wr_state_reg <= W_IDLE;
            rd_state_reg <= R_IDLE;
        end else begin
            wr_state_reg <= wr_state_next;
            rd_state_reg <= rd_state_next;
        end
    end

    // Control registers; only byte lanes with their strobe set are written.
    always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
        if (!s_axi_intr_aresetn) begin
            gie_reg <= 1'b0;
            ier_reg <= '0;
        end else if (wr_fire) begin
            if (wr_idx == ADDR_GIE[4:2] && s_axi_intr.wstrb[0]) begin
                gie_reg <= s_axi_intr.wdata[0];
            end
            if (wr_idx == ADDR_IER[4:2]) begin
                ier_reg <= ((ier_reg & ~wr_mask) | wr_bits) & SRC_MASK;
            end
        end
    end

    always_comb begin
        ack_clr = '0;
        if (wr_fire && wr_idx == ADDR_IAR[4:2]) begin
            ack_clr = wr_bits[N-1:0];
        end
    end

`ifdef PMOD_INTR_SW_TRIGGER_EN
    always_comb begin
        sw_set = '0;
        if (wr_fire && wr_idx == ADDR_ITR[4:2]) begin
            sw_set = wr_bits[N-1:0];
        end
    end
`else
    assign sw_set = '0;
`endif

    pmod_intr_detect #(
        .N    (N),
        .SENS (C_INTR_SENSITIVITY)
    ) u_detect (
        .clk    (s_axi_intr_aclk),
        .rst_n  (s_axi_intr_aresetn),
        .src    (intr_src),
        .sw_set (sw_set),
        .clr    (ack_clr),
        .isr    (isr)
    );

    assign isr_full = 32'(isr);
    assign ipr_full = isr_full & ier_reg;

    // Read data is captured from current register values, so a read that
    // coincides with a write sees the pre-write contents.
    always_comb begin
        rdata_next = '0;
        case (rd_idx)
            ADDR_GIE[4:2]: rdata_next = {31'b0, gie_reg};
            ADDR_IER[4:2]: rdata_next = ier_reg;
            ADDR_ISR[4:2]: rdata_next = isr_full;
            ADDR_IPR[4:2]: rdata_next = ipr_full;
            default:       rdata_next = '0;
        endcase
    end

    always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
        if (!s_axi_intr_aresetn) begin
            rdata_reg <= '0;
        end else if (rd_fire) begin
            rdata_reg <= rdata_next;
        end
    end

    assign s_axi_intr.rdata = rdata_reg;

    always_comb begin
        irq_next = (gie_reg && (|ipr_full)) ? IRQ_ON : ~IRQ_ON;
    end

    always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
        if (!s_axi_intr_aresetn) begin
            irq_reg <= ~IRQ_ON;
        end else begin
            irq_reg <= irq_next;
        end
    end

    assign irq = irq_reg;

endmodule

// File: tb/tb_pmod_intr_axil_slave.sv
// Directed bench for pmod_intr_axil_slave; a monitor checks R and B beats
// against queues filled by the stimulus, irq/handshake levels are checked inline.
module tb_pmod_intr_axil_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] intr_src = 4'b0;
    logic       irq;

    always #5 clk = ~clk;

    pmod_intr_axil_slave_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    pmod_intr_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .C_NUM_OF_INTR      (4),
        .C_INTR_SENSITIVITY (32'hFFFF_FFF7),
        .C_IRQ_ACTIVE_STATE (1)
    ) dut (
        .s_axi_intr_aclk    (clk),
        .s_axi_intr_aresetn (rst_n),
        .s_axi_intr         (bus),
        .intr_src           (intr_src),
        .irq                (irq)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } rd_exp_t;

    int total = 0;
    int bad   = 0;
    rd_exp_t    exp_r[$];
    logic [1:0] exp_b[$];
    rd_exp_t    cur_r;
    logic [1:0] cur_b;

    // Monitor: every completed R or B beat is matched against the queue head.
    always @(negedge clk) begin
        if (bus.rvalid && bus.rready) begin
            total++;
            if (exp_r.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got rdata=%h, none expected", bus.rdata);
            end else begin
                cur_r = exp_r.pop_front();
                if (bus.rdata !== cur_r.data || bus.rresp !== 2'b00) begin
                    bad++;
                    $display("FAIL rd@%h: got rdata=%h rresp=%0d, expected %h rresp=0",
                             cur_r.addr, bus.rdata, bus.rresp, cur_r.data);
                end else begin
                    $display("read  @%h = %h ok", cur_r.addr, bus.rdata);
                end
            end
        end
        if (bus.bvalid && bus.bready) begin
            total++;
            if (exp_b.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got bresp=%0d, none expected", bus.bresp);
            end else begin
                cur_b = exp_b.pop_front();
                if (bus.bresp !== cur_b) begin
                    bad++;
                    $display("FAIL bresp: got %0d, expected %0d", bus.bresp, cur_b);
                end else begin
                    $display("write resp %0d ok", bus.bresp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string what);
        total++;
        bad++;
        $display("FAIL timeout: %s not seen within 20 cycles", what);
    endtask

    // Wait (bounded) at negedges for a level; returns with time at a negedge.
    task automatic wait_aw();
        int n = 0;
        @(negedge clk);
        while (!(bus.awready && bus.wready) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) timeout("awready");
    endtask

    task automatic wait_b();
        int n = 0;
        @(negedge clk);
        while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) timeout("bvalid");
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_b.push_back(2'b00);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        wait_aw();
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        wait_b();
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] e);
        int n = 0;
        exp_r.push_back('{addr: a, data: e});
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
        @(negedge clk);
        while (!bus.arready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) timeout("arready");
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) timeout("rvalid");
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        tick(3);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_bvalid", {31'b0, bus.bvalid}, 32'h0);
        check("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        rst_n = 1'b1;
        tick(2);

        for (int a = 0; a < 6; a++) axi_read(5'(a * 4), 32'h0);

        // Enable and fire source 0 (edge): irq two cycles after the edge.
        axi_write(5'h00, 32'h1, 4'hF);
        axi_write(5'h04, 32'h1, 4'hF);
        intr_src[0] = 1'b1;
        tick(1);
        intr_src[0] = 1'b0;
        check("irq_edge+1", {31'b0, irq}, 32'h0);
        tick(1);
        check("irq_edge+2", {31'b0, irq}, 32'h1);
        axi_read(5'h10, 32'h1);
        axi_read(5'h08, 32'h1);

        axi_write(5'h0C, 32'h1, 4'hF);
        check("irq_after_ack", {31'b0, irq}, 32'h0);
        axi_read(5'h10, 32'h0);

        // Pending with IER off, then enabling raises irq.
        axi_write(5'h04, 32'h0, 4'hF);
        intr_src[0] = 1'b1; tick(1); intr_src[0] = 1'b0;
        tick(3);
        check("irq_ier_off", {31'b0, irq}, 32'h0);
        axi_read(5'h08, 32'h1);
        axi_read(5'h10, 32'h0);
        axi_write(5'h04, 32'h1, 4'hF);
        check("irq_ier_on", {31'b0, irq}, 32'h1);
        axi_write(5'h0C, 32'h1, 4'hF);
        check("irq_cleared", {31'b0, irq}, 32'h0);

        // Edge arriving on the same clock as the IAR write: set wins.
        intr_src[0] = 1'b1;
        axi_write(5'h0C, 32'h1, 4'hF);
        intr_src[0] = 1'b0;
        axi_read(5'h08, 32'h1);
        check("irq_set_wins", {31'b0, irq}, 32'h1);
        axi_write(5'h0C, 32'h1, 4'hF);
        axi_read(5'h08, 32'h0);

        // Byte strobes and unimplemented IER bits.
        axi_write(5'h04, 32'hFFFF_FFFF, 4'h0);
        axi_read(5'h04, 32'h1);
        axi_write(5'h04, 32'hFFFF_FFFF, 4'hF);
        axi_read(5'h04, 32'hF);
        axi_write(5'h04, 32'h0, 4'hE);
        axi_read(5'h04, 32'hF);
        axi_write(5'h04, 32'hE, 4'h1);
        axi_read(5'h04, 32'hE);
        axi_write(5'h00, 32'h0, 4'h0);
        axi_read(5'h00, 32'h1);

        // Level source 3 held high survives an ack.
        intr_src[3] = 1'b1;
        tick(1);
        axi_write(5'h0C, 32'h8, 4'hF);
        axi_read(5'h08, 32'h8);
        axi_read(5'h10, 32'h8);
        check("irq_level", {31'b0, irq}, 32'h1);
        intr_src[3] = 1'b0;
        axi_write(5'h0C, 32'h8, 4'hF);
        axi_read(5'h08, 32'h0);
        check("irq_level_clr", {31'b0, irq}, 32'h0);

        // Edge source held high latches only once.
        intr_src[0] = 1'b1;
        tick(2);
        axi_write(5'h0C, 32'h1, 4'hF);
        axi_read(5'h08, 32'h0);
        intr_src[0] = 1'b0;

        // Unmapped offsets and write-only IAR.
        axi_read(5'h18, 32'h0);
        axi_read(5'h1C, 32'h0);
        axi_write(5'h18, 32'hFFFF_FFFF, 4'hF);
        axi_read(5'h00, 32'h1);
        axi_read(5'h04, 32'hE);
        axi_read(5'h0C, 32'h0);

`ifdef PMOD_INTR_SW_TRIGGER_EN
        axi_write(5'h14, 32'h4, 4'hF);
        axi_read(5'h08, 32'h4);
        axi_write(5'h14, 32'h2, 4'h0);
        axi_read(5'h08, 32'h4);
        check("irq_sw_trig", {31'b0, irq}, 32'h1);
        axi_write(5'h0C, 32'h4, 4'hF);
        axi_read(5'h08, 32'h0);
        axi_read(5'h14, 32'h0);
`else
        axi_write(5'h14, 32'h4, 4'hF);
        axi_read(5'h08, 32'h0);
        axi_read(5'h14, 32'h0);
`endif

        // Back-pressure on B: second AW+W must wait until the response drains.
        exp_b.push_back(2'b00);
        exp_b.push_back(2'b00);
        bus.bready = 1'b0;
        bus.awaddr = 5'h00; bus.wdata = 32'h0; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        wait_aw();
        @(posedge clk); #1;
        bus.awaddr = 5'h04; bus.wdata = 32'h3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bhold_bvalid", {31'b0, bus.bvalid}, 32'h1);
            check("bhold_awready", {31'b0, bus.awready}, 32'h0);
        end
        @(posedge clk); #1;
        bus.bready = 1'b1;
        wait_aw();
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        wait_b();
        @(posedge clk); #1;
        axi_read(5'h00, 32'h0);
        axi_read(5'h04, 32'h3);

        // Read and write to IER in the same cycle: read sees the old value.
        exp_b.push_back(2'b00);
        exp_r.push_back('{addr: 5'h04, data: 32'h3});
        bus.awaddr = 5'h04; bus.wdata = 32'h5; bus.wstrb = 4'hF;
        bus.araddr = 5'h04;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(negedge clk);
        check("simul_arready", {31'b0, bus.arready}, 32'h1);
        check("simul_awready", {31'b0, bus.awready}, 32'h1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        tick(3);
        axi_read(5'h04, 32'h5);

        // Reset in the middle of a read: the pending R beat is dropped.
        bus.rready = 1'b0;
        bus.araddr = 5'h04; bus.arvalid = 1'b1;
        @(negedge clk);
        check("mid_arready", {31'b0, bus.arready}, 32'h1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rvalid_rst", {31'b0, bus.rvalid}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        bus.rready = 1'b1;
        tick(3);
        check("post_rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
        check("post_rst_bvalid", {31'b0, bus.bvalid}, 32'h0);
        check("post_rst_irq", {31'b0, irq}, 32'h0);
        axi_read(5'h04, 32'h0);

        tick(2);
        check("rd_queue_empty", 32'(exp_r.size()), 32'h0);
        check("wr_queue_empty", 32'(exp_b.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
